// File: rtl/inc_sequencer.sv
// inc_sequencer: counter controller around an external WIDTH-bit incrementor.
// Streams start_val..end_val (inclusive, wrapping) over valid/ready, then pulses done.
module inc_sequencer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] end_val,
    output logic [WIDTH-1:0] inc_a,
    input  logic [WIDTH-1:0] inc_y,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state, datapath capture and registered-output decode
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        limit_d     = limit_q;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d = start_val;
                    limit_d = end_val;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // out_valid_q is always high in RUN, so out_ready alone marks a handshake
                if (out_ready) begin
                    if (count_q == limit_q) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = inc_y;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of the decode of the next state
        out_valid_d = (state_d == ST_RUN);
        busy_d      = (state_d == ST_RUN) || (state_d == ST_DONE);
        done_d      = (state_d == ST_DONE);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            limit_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            limit_q     <= limit_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Incrementor operand comes straight from the count register, breaking any loop
    assign inc_a     = count_q;
    assign out_data  = count_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
